// File: rtl/aDefinitions.v
// aDefinitions.v - shared instruction-set definitions: width macros, opcode
// constants and the jump-detect helper used by the decode/issue front end.
`ifndef A_DEFINITIONS_V
`define A_DEFINITIONS_V

`define INSTRUCTION_WIDTH     32
`define INSTRUCTION_OP_LENGTH 5
`define ROM_ADDRESS_WIDTH     10

package idu_defs_pkg;

   localparam int DEF_IW  = `INSTRUCTION_WIDTH;
   localparam int DEF_OPW = `INSTRUCTION_OP_LENGTH;
   localparam int DEF_AW  = `ROM_ADDRESS_WIDTH;

   typedef logic [`INSTRUCTION_OP_LENGTH-1:0] opcode_t;

   localparam opcode_t RETURN = 'd0;
   localparam opcode_t JGEX   = 'd10;
   localparam opcode_t JLEX   = 'd11;
   localparam opcode_t JGX    = 'd12;
   localparam opcode_t JLX    = 'd13;
   localparam opcode_t JEQX   = 'd14;
   localparam opcode_t JNEX   = 'd15;
   localparam opcode_t JGEZ   = 'd16;
   localparam opcode_t JLEZ   = 'd17;
   localparam opcode_t JGZ    = 'd18;
   localparam opcode_t JLZ    = 'd19;
   localparam opcode_t JEQZ   = 'd20;
   localparam opcode_t JNEZ   = 'd21;

   // True for any conditional jump; EXE resolves these with taken/not-taken.
   function automatic logic isJump(input opcode_t op);
      case (op)
         JGEX, JLEX, JGX, JLX, JEQX, JNEX,
         JGEZ, JLEZ, JGZ, JLZ, JEQZ, JNEZ: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

`endif

// File: rtl/instruction_latch_unit_pkg.sv
// instruction_latch_unit_pkg - local types for the instruction latch unit.
`include "aDefinitions.v"

package instruction_latch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      RUN         = 2'd1,
      BRANCH_WAIT = 2'd2,
      DRAIN       = 2'd3
   } iduState_t;

endpackage

// File: rtl/idu_skid_fifo.sv
// idu_skid_fifo - two-entry FIFO holding {instruction, ip} between fetch and EXE.
// Head is read straight from the storage register selected by the read pointer.
module idu_skid_fifo #(
   parameter int W = 42
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         iPush,
   input  logic         iPop,
   input  logic         iFlush,
   input  logic [W-1:0] iData,
   output logic [W-1:0] oHead,
   output logic         oFull,
   output logic         oEmpty,
   output logic [1:0]   oCount
);

   logic [W-1:0] mem [2];
   logic         wrPtr;
   logic         rdPtr;
   logic [1:0]   count;
   logic         pushEff;
   logic         popEff;

   assign oFull   = (count == 2'd2);
   assign oEmpty  = (count == 2'd0);
   assign oCount  = count;
   assign oHead   = mem[rdPtr];
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign pushEff = iPush && (!oFull || iPop);
   assign popEff  = iPop && !oEmpty;

   // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else if (iFlush) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (pushEff) wrPtr <= ~wrPtr;
         if (popEff)  rdPtr <= ~rdPtr;
         count <= count + {1'b0, pushEff} - {1'b0, popEff};
      end
   end

   // Entry storage; cleared on reset so the issue fields read zero.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (pushEff && !iFlush) begin
         mem[wrPtr] <= iData;
      end
   end

endmodule

// File: rtl/instruction_latch_unit.sv
// instruction_latch_unit - latches fetched instructions into a 2-entry FIFO and
// issues them to EXE, pausing on jumps until EXE resolves them and draining
// after RETURN.
// Optional feature: define IDU_OVERFLOW_CHECK_EN to build the sticky overflow
// detector; otherwise oOverflowError is tied low.
module instruction_latch_unit
   import idu_defs_pkg::*;
   import instruction_latch_unit_pkg::*;
#(
   parameter int IW  = DEF_IW,
   parameter int OPW = DEF_OPW,
   parameter int AW  = DEF_AW
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iInstructionAvalable,
   input  logic [IW-1:0]     iEncodedInstruction,
   input  logic [AW-1:0]     iInstructionPointer,
   output logic              oDecodeUnitLatchedValues,
   output logic              oIDUBusy,
   output logic              oIssueValid,
   output logic [OPW-1:0]    oIssueOpcode,
   output logic [IW-OPW-1:0] oIssueOperands,
   output logic [AW-1:0]     oIssueIp,
   input  logic              iExeReady,
   input  logic              iBranchTaken,
   input  logic              iBranchNotTaken,
   output logic              oLastIssued,
   output logic              oReturnValue,
   output logic              oOverflowError
);

   localparam int FW = IW + AW;

   iduState_t      state;
   iduState_t      nextState;
   logic [FW-1:0]  head;
   logic [OPW-1:0] headOp;
   logic           full;
   logic           empty;
   logic [1:0]     count;
   logic           accept;
   logic           acceptReturn;
   logic           acceptJump;
   logic           takenFlush;
   logic           fifoFlush;
   logic           push;

   assign headOp         = head[FW-1 -: OPW];
   assign oIssueOpcode   = headOp;
   assign oIssueOperands = head[FW-OPW-1:AW];
   assign oIssueIp       = head[AW-1:0];
   assign oIssueValid    = !empty && (state == RUN);
   assign oIDUBusy       = !empty || (state != IDLE);

   assign accept       = oIssueValid && iExeReady;
   assign acceptReturn = accept && (headOp == RETURN);
   assign acceptJump   = accept && isJump(headOp);
   // Not-taken wins when EXE raises both resolution lines.
   assign takenFlush   = (state == BRANCH_WAIT) && iBranchTaken && !iBranchNotTaken;
   // Words buffered behind a RETURN are dead; DRAIN discards them so it can reach IDLE.
   assign fifoFlush    = takenFlush || (state == DRAIN);
   // A RETURN being accepted closes the stream, so nothing is latched alongside it.
   assign push = iInstructionAvalable && (state != DRAIN) && !takenFlush &&
                 !acceptReturn && (!full || accept);

   idu_skid_fifo #(.W(FW)) uFifo (
      .Clock  (Clock),
      .Reset  (Reset),
      .iPush  (push),
      .iPop   (accept),
      .iFlush (fifoFlush),
      .iData  ({iEncodedInstruction, iInstructionPointer}),
      .oHead  (head),
      .oFull  (full),
      .oEmpty (empty),
      .oCount (count)
   );

   // State register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state: start on first capture, park on jumps, wind down after RETURN.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:        if (push) nextState = RUN;
         RUN: begin
            if (acceptReturn)    nextState = DRAIN;
            else if (acceptJump) nextState = BRANCH_WAIT;
         end
         BRANCH_WAIT: if (iBranchTaken || iBranchNotTaken) nextState = RUN;
         DRAIN:       if (count == 2'd0) nextState = IDLE;
         default:     nextState = IDLE;
      endcase
   end

   // Registered capture acknowledge, RETURN pulse and held return value.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oDecodeUnitLatchedValues <= 1'b0;
         oLastIssued              <= 1'b0;
         oReturnValue             <= 1'b0;
      end else begin
         oDecodeUnitLatchedValues <= push;
         oLastIssued              <= acceptReturn;
         if (acceptReturn) oReturnValue <= head[AW];
      end
   end

`ifdef IDU_OVERFLOW_CHECK_EN
   logic overflow;

   // Sticky flag for offers that cannot be taken: FIFO full with no accept, or DRAIN.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) overflow <= 1'b0;
      else if (iInstructionAvalable && ((full && !accept) || (state == DRAIN)))
         overflow <= 1'b1;
   end

   assign oOverflowError = overflow;
`else
   assign oOverflowError = 1'b0;
`endif

endmodule
